scnn_layer_sequencer: RTL and testbench

Control FSM that runs one convolution layer on the 4-PE SCNN datapath, tile by tile. It accepts a layer job, clears the PE accumulation buffers, and issues one start pulse per weight tile. It waits for every PE to report done, then pulses accumulate. After the last tile it streams the output-buffer indices to the writeback side under backpressure and signals completion.

---
 rtl/scnn_pkg.sv | 25 ++
 rtl/scnn_done_collector.sv | 32 +++
 rtl/scnn_layer_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_scnn_layer_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/scnn_pkg.sv
// Shared types for the SCNN layer sequencer: FSM state encoding, default
// PE count, tile-counter width and the layer dimension bundle handed to the PEs.
// Ports: none (package).
package scnn_pkg;

  localparam int SCNN_NUM_PE = 4;
  localparam int SCNN_TILE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    START,
    WAIT,
    ACC,
    DRAIN,
    DONE
  } seq_state_e;

  // Dimensions latched at job accept and driven to every PE.
  typedef struct packed {
    logic [7:0] ip_dim;
    logic [3:0] wt_dim;
  } scnn_dims_t;

endpackage

// File: rtl/scnn_done_collector.sv
// Sticky collector of per-PE done flags for the current tile.
// Ports: i_clr empties the mask, i_en ORs i_done into it, o_all_done is high
// when every PE is either already recorded or reporting done this cycle.
module scnn_done_collector
  import scnn_pkg::*;
#(
  parameter int NUM_PE = SCNN_NUM_PE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [NUM_PE-1:0] i_done,
  output logic              o_all_done
);

  logic [NUM_PE-1:0] r_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '0;
    end else if (i_clr) begin
      r_mask <= '0;
    end else if (i_en) begin
      r_mask <= r_mask | i_done;
    end
  end

  // Includes this cycle's flags so a level or pulse seen now counts at once.
  assign o_all_done = &(r_mask | i_done);

endmodule

// File: rtl/scnn_layer_sequencer.sv
// Layer control FSM for the 4-PE SCNN datapath: accepts a job, clears the
// accumulators, runs each weight tile (start -> wait all done -> accumulate),
// then drains the output-buffer indices under out_valid/out_ready backpressure.
// Ports: job_* handshake in, cfg_*/tile_idx/acc_clear/pe_start/acc_en to the
// PEs, pe_done from the PEs, out_* writeback stream, busy/done/err status.
// Optional watchdog: define SCNN_SEQ_TIMEOUT_EN to abort a tile stuck in WAIT
// for TIMEOUT_CYCLES cycles (err=1); otherwise err is tied low.
module scnn_layer_sequencer
  import scnn_pkg::*;
#(
  parameter int NUM_PE         = SCNN_NUM_PE,
  parameter int PARAM_IP_SIZE  = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             job_valid,
  output logic                             job_ready,
  input  logic [7:0]                       job_ip_dim,
  input  logic [3:0]                       job_wt_dim,
  input  logic [SCNN_TILE_W-1:0]           job_num_tiles,
  output logic [7:0]                       cfg_ip_dim,
  output logic [3:0]                       cfg_wt_dim,
  output logic [SCNN_TILE_W-1:0]           tile_idx,
  output logic                             acc_clear,
  output logic                             pe_start,
  input  logic [NUM_PE-1:0]                pe_done,
  output logic                             acc_en,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(PARAM_IP_SIZE)-1:0] out_idx,
  output logic                             out_last,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  localparam int               IDX_W    = $clog2(PARAM_IP_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PARAM_IP_SIZE - 1);
  localparam int               WD_W     = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_e             r_state;
  seq_state_e             w_state_nxt;
  scnn_dims_t             r_cfg;
  logic [SCNN_TILE_W-1:0] r_num_tiles;
  logic [SCNN_TILE_W-1:0] r_tile_idx;
  logic [IDX_W-1:0]       r_out_idx;

  logic w_accept;
  logic w_all_done;
  logic w_last_tile;
  logic w_last_beat;
  logic w_beat;
  logic w_timeout;

  assign w_accept    = (r_state == IDLE) && job_valid;
  assign w_last_tile = (r_tile_idx == r_num_tiles - 8'd1);
  assign w_last_beat = (r_out_idx == LAST_IDX);
  assign w_beat      = (r_state == DRAIN) && out_ready;

  // Mask is emptied in START, so done flags seen there do not count.
  scnn_done_collector #(
    .NUM_PE(NUM_PE)
  ) u_done_collector (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (r_state == START),
    .i_en      (r_state == WAIT),
    .i_done    (pe_done),
    .o_all_done(w_all_done)
  );

`ifdef SCNN_SEQ_TIMEOUT_EN
  logic [WD_W-1:0] r_wdog;
  logic            r_err;

  // r_wdog is 0 in the first WAIT cycle, so the limit hits on WAIT cycle N.
  assign w_timeout = (r_state == WAIT) && !w_all_done &&
                     (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == START) begin
        r_wdog <= '0;
      end else if (r_state == WAIT) begin
        r_wdog <= r_wdog + WD_W'(1);
      end
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  logic [WD_W-1:0] w_unused_wd;

  assign w_unused_wd = WD_W'(TIMEOUT_CYCLES);
  assign w_timeout   = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    job_ready   = 1'b0;
    busy        = 1'b1;
    acc_clear   = 1'b0;
    pe_start    = 1'b0;
    acc_en      = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        job_ready = 1'b1;
        busy      = 1'b0;
        if (job_valid) w_state_nxt = CLEAR;
      end
      CLEAR: begin
        acc_clear   = 1'b1;
        w_state_nxt = (r_num_tiles == '0) ? DONE : START;
      end
      START: begin
        pe_start    = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (w_all_done) begin
          w_state_nxt = ACC;
        end else if (w_timeout) begin
          w_state_nxt = DONE;
        end
      end
      ACC: begin
        acc_en      = 1'b1;
        w_state_nxt = w_last_tile ? DRAIN : START;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = w_last_beat;
        if (out_ready && w_last_beat) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg       <= '0;
      r_num_tiles <= '0;
      r_tile_idx  <= '0;
      r_out_idx   <= '0;
    end else begin
      if (w_accept) begin
        r_cfg       <= '{ip_dim: job_ip_dim, wt_dim: job_wt_dim};
        r_num_tiles <= job_num_tiles;
        r_tile_idx  <= '0;
      end else if ((r_state == ACC) && !w_last_tile) begin
        r_tile_idx <= r_tile_idx + 8'd1;
      end
      // Wrap to 0 on the final beat so the next job drains from entry 0.
      if (w_beat) begin
        r_out_idx <= w_last_beat ? '0 : r_out_idx + IDX_W'(1);
      end
    end
  end

  assign cfg_ip_dim = r_cfg.ip_dim;
  assign cfg_wt_dim = r_cfg.wt_dim;
  assign tile_idx   = r_tile_idx;
  assign out_idx    = r_out_idx;

endmodule

// File: tb/tb_scnn_layer_sequencer.sv
// Directed bench for scnn_layer_sequencer: a table of whole-job vectors with
// hand-computed cycle counts, plus reset-state, mid-job reset and watchdog sequences.
module tb_scnn_layer_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       job_valid;
  logic       job_ready;
  logic [7:0] job_ip_dim;
  logic [3:0] job_wt_dim;
  logic [7:0] job_num_tiles;
  logic [7:0] cfg_ip_dim;
  logic [3:0] cfg_wt_dim;
  logic [7:0] tile_idx;
  logic       acc_clear;
  logic       pe_start;
  logic [3:0] pe_done;
  logic       acc_en;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_idx;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       err;

  int n_chk = 0;
  int n_err = 0;

  scnn_layer_sequencer #(
    .NUM_PE(4),
    .PARAM_IP_SIZE(16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_ip_dim(job_ip_dim), .job_wt_dim(job_wt_dim), .job_num_tiles(job_num_tiles),
    .cfg_ip_dim(cfg_ip_dim), .cfg_wt_dim(cfg_wt_dim), .tile_idx(tile_idx),
    .acc_clear(acc_clear), .pe_start(pe_start), .pe_done(pe_done), .acc_en(acc_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [7:0]      tiles;
    logic [7:0]      ip;
    logic [3:0]      wt;
    logic [3:0][7:0] dly;    // per-PE done delay after pe_start, 0 = never
    logic [3:0]      rdy;    // out_ready pattern, indexed by drain cycle mod 4
    bit              glitch; // pulse all pe_done during the START cycle
    int              exp_done;
    int              exp_start;
    int              exp_acc;
    int              exp_beats;
    int              exp_err;
  } job_vec_t;

  typedef struct {
    int done_c, n_start, n_acc, n_clear, n_beats;
    int seq_ok, accen_ok, err_done, err_c1, ready_after, timed_out;
  } res_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " job_ready"}, int'(job_ready), 1);
    chk({tag, " busy"},      int'(busy), 0);
    chk({tag, " done"},      int'(done), 0);
    chk({tag, " err"},       int'(err), 0);
    chk({tag, " pe_start"},  int'(pe_start), 0);
    chk({tag, " acc_clear"}, int'(acc_clear), 0);
    chk({tag, " acc_en"},    int'(acc_en), 0);
    chk({tag, " out_valid"}, int'(out_valid), 0);
    chk({tag, " out_last"},  int'(out_last), 0);
    chk({tag, " tile_idx"},  int'(tile_idx), 0);
    chk({tag, " out_idx"},   int'(out_idx), 0);
    chk({tag, " cfg_ip"},    int'(cfg_ip_dim), 0);
    chk({tag, " cfg_wt"},    int'(cfg_wt_dim), 0);
  endtask

  task automatic run_job(input job_vec_t v, output res_t r);
    int c, s, dmax, beat, dk, never, wt;
    bit prev_v, prev_r, done_seen;
    logic [3:0] prev_idx;
    r = '{default: 0};
    r.seq_ok = 1; r.accen_ok = 1;
    dmax = 0; never = 0;
    for (int i = 0; i < 4; i++) begin
      if (v.dly[i] == 8'd0) never = 1;
      else if (int'(v.dly[i]) > dmax) dmax = int'(v.dly[i]);
    end
    wt = 0;
    while (!job_ready && wt < 50) begin step(); wt++; end
    job_valid = 1'b1; job_ip_dim = v.ip; job_wt_dim = v.wt; job_num_tiles = v.tiles;
    pe_done = '0; out_ready = 1'b0;
    c = 0; s = -1000; beat = 0; dk = 0; prev_v = 0; prev_r = 0; prev_idx = '0; done_seen = 0;
    while (!done_seen && r.timed_out == 0) begin
      step(); c++;
      // Keep offering a different job; it must be ignored while busy.
      job_ip_dim = ~v.ip; job_wt_dim = ~v.wt; job_num_tiles = v.tiles + 8'd7;
      if (c == 1) r.err_c1 = int'(err);
      if (busy !== 1'b1 || job_ready !== 1'b0) r.seq_ok = 0;
      if (acc_clear) begin r.n_clear++; if (c != 1) r.seq_ok = 0; end
      if (pe_start) begin
        if (int'(tile_idx) != r.n_start) r.seq_ok = 0;
        if (cfg_ip_dim !== v.ip || cfg_wt_dim !== v.wt) r.seq_ok = 0;
        r.n_start++; s = c;
      end
      if (acc_en) begin
        r.n_acc++;
        if (never != 0 || c != s + dmax + 1) r.accen_ok = 0;
      end
      if (prev_v && !prev_r && (!out_valid || out_idx !== prev_idx)) r.seq_ok = 0;
      if (out_valid && int'(out_idx) != beat) r.seq_ok = 0;
      if (out_last !== (out_valid && beat == 15)) r.seq_ok = 0;
      out_ready = 1'b0;
      if (out_valid) begin out_ready = v.rdy[dk % 4]; dk++; end
      if (out_valid && out_ready) begin r.n_beats++; beat++; end
      prev_v = out_valid; prev_r = out_ready; prev_idx = out_idx;
      pe_done = '0;
      for (int i = 0; i < 4; i++)
        if ((v.dly[i] != 8'd0 && c == s + int'(v.dly[i])) || (v.glitch && c == s))
          pe_done[i] = 1'b1;
      if (done) begin done_seen = 1; r.done_c = c; r.err_done = int'(err); end
      if (c > 3000) r.timed_out = 1;
    end
    job_valid = 1'b0; pe_done = '0; out_ready = 1'b0;
    step();
    r.ready_after = int'(job_ready && !done && !busy);
  endtask

  task automatic apply_vec(input job_vec_t v);
    res_t r;
    run_job(v, r);
    chk({v.name, " timed_out"},   r.timed_out, 0);
    chk({v.name, " done_cycle"},  r.done_c, v.exp_done);
    chk({v.name, " pe_starts"},   r.n_start, v.exp_start);
    chk({v.name, " acc_ens"},     r.n_acc, v.exp_acc);
    chk({v.name, " acc_clears"},  r.n_clear, 1);
    chk({v.name, " beats"},       r.n_beats, v.exp_beats);
    chk({v.name, " seq_ok"},      r.seq_ok, 1);
    chk({v.name, " acc_en_time"}, r.accen_ok, 1);
    chk({v.name, " err_at_done"}, r.err_done, v.exp_err);
    chk({v.name, " err_cleared"}, r.err_c1, 0);
    chk({v.name, " ready_after"}, r.ready_after, 1);
  endtask

  job_vec_t vecs[6];

  initial begin
    // exp_done = tiles*(dmax+2) + 2 + drain cycles; tiles=0 finishes at cycle 2.
    vecs[0] = '{"single",    8'd1,   8'd8,  4'd5, {8'd3, 8'd3, 8'd3, 8'd3}, 4'b1111, 1'b0, 23,  1,   1,   16, 0};
    vecs[1] = '{"stagger3",  8'd3,   8'd20, 4'd3, {8'd7, 8'd5, 8'd3, 8'd1}, 4'b1111, 1'b0, 45,  3,   3,   16, 0};
    vecs[2] = '{"zero_tile", 8'd0,   8'd4,  4'd2, {8'd1, 8'd1, 8'd1, 8'd1}, 4'b1111, 1'b0, 2,   0,   0,   0,  0};
    vecs[3] = '{"bp_1001",   8'd1,   8'd8,  4'd5, {8'd3, 8'd3, 8'd3, 8'd3}, 4'b1001, 1'b0, 39,  1,   1,   16, 0};
    vecs[4] = '{"tiles255",  8'd255, 8'd9,  4'd7, {8'd1, 8'd1, 8'd1, 8'd1}, 4'b1111, 1'b0, 783, 255, 255, 16, 0};
    vecs[5] = '{"glitch2",   8'd2,   8'd33, 4'd9, {8'd1, 8'd4, 8'd1, 8'd2}, 4'b1111, 1'b1, 30,  2,   2,   16, 0};

    rst_n = 1'b1; job_valid = 1'b0; job_ip_dim = '0; job_wt_dim = '0; job_num_tiles = '0;
    pe_done = '0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

    // Reset asserted in WAIT of tile 1 of a 3-tile job (all done at 7, pe_start 9).
    job_valid = 1'b1; job_ip_dim = 8'd12; job_wt_dim = 4'd6; job_num_tiles = 8'd3;
    for (int k = 1; k <= 11; k++) begin
      step();
      job_valid = 1'b0;
      pe_done = (k == 7) ? 4'hF : 4'h0;
    end
    chk("midrst tile_idx before", int'(tile_idx), 1);
    chk("midrst busy before", int'(busy), 1);
    pe_done = '0;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk) rst_n = 1'b1;
    step();
    apply_vec(vecs[0]);

`ifdef SCNN_SEQ_TIMEOUT_EN
    begin
      job_vec_t tv;
      // WAIT cycles 3..10 expire, DONE with err at 11.
      tv = '{"timeout", 8'd2, 8'd8, 4'd5, {8'd3, 8'd0, 8'd3, 8'd3}, 4'b1111, 1'b0, 11, 1, 0, 0, 1};
      apply_vec(tv);
      chk("timeout err sticky idle", int'(err), 1);
      apply_vec(vecs[0]);
      chk("timeout err after next job", int'(err), 0);
    end
`else
    chk("err tied low", int'(err), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
